snn_lif_layer: RTL and testbench

SNN_LIF_LAYER -- requirements
Module: snn_lif_layer

---
 rtl/snn_pkg.sv | 16 +
 rtl/snn_lif_neuron.sv | 77 +++++++
 rtl/snn_lif_layer.sv | 149 ++++++++++++++
 tb/tb_snn_lif_layer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants and FSM state encoding for the LIF spiking layer.
package snn_pkg;
    localparam int N_IN_DEF       = 25;
    localparam int N_OUT_DEF      = 10;
    localparam int W_W_DEF        = 4;
    localparam int W_INIT_DEF     = 8;
    localparam int V_W_DEF        = 12;
    localparam int THRESH_DEF     = 400;
    localparam int LEAK_SHIFT_DEF = 4;
    localparam int T_WIN_DEF      = 336;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_INTEG = 2'd1;
    localparam state_t ST_LEARN = 2'd2;
endpackage

// File: rtl/snn_lif_neuron.sv
// One LIF neuron: weight row, synaptic sum, leak, threshold/reset and learn update.
// Weight registers exist only when SNN_LEARN_EN is defined; otherwise the row is constant.
module snn_lif_neuron
    import snn_pkg::*;
#(
    parameter int N_IN       = N_IN_DEF,
    parameter int W_W        = W_W_DEF,
    parameter int W_INIT     = W_INIT_DEF,
    parameter int V_W        = V_W_DEF,
    parameter int THRESH     = THRESH_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_integ,
    input  logic            i_learn,
    input  logic [N_IN-1:0] i_pattern,
    input  logic [N_IN-1:0] i_rand,
    output logic            o_fire
);
    localparam int SYN_W = $clog2(N_IN * (2**W_W - 1) + 1);
    localparam int NV_W  = ((V_W > SYN_W) ? V_W : SYN_W) + 1;
    localparam logic [W_W-1:0] W_RST = W_W'(W_INIT);
    localparam logic [V_W-1:0] V_MAX = '1;
    localparam logic [V_W-1:0] V_TH  = V_W'(THRESH);

    logic [N_IN-1:0][W_W-1:0] w_wt;
    logic [N_IN-1:0]          w_eff;
    logic [SYN_W-1:0]         w_syn;
    logic [NV_W-1:0]          w_nv;
    logic [V_W-1:0]           w_nv_sat;
    logic [V_W-1:0]           r_v;

    assign w_eff = i_pattern & i_rand;

    always_comb begin
        w_syn = '0;
        for (int i = 0; i < N_IN; i++)
            if (w_eff[i]) w_syn = w_syn + SYN_W'(w_wt[i]);
    end

    // Extra headroom bit so the saturation compare sees true overflow.
    assign w_nv     = NV_W'(r_v) - NV_W'(r_v >> LEAK_SHIFT) + NV_W'(w_syn);
    assign w_nv_sat = (w_nv > NV_W'(V_MAX)) ? V_MAX : w_nv[V_W-1:0];
    assign o_fire   = i_integ && (w_nv_sat >= V_TH);

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) r_v <= '0;
        else if (i_integ)    r_v <= o_fire ? '0 : w_nv_sat;
    end

`ifdef SNN_LEARN_EN
    localparam logic [W_W-1:0] W_MAX = '1;
    logic [N_IN-1:0][W_W-1:0] r_w;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) r_w[i] <= W_RST;
        end else if (i_learn) begin
            for (int i = 0; i < N_IN; i++) begin
                if (i_pattern[i]) begin
                    if (r_w[i] != W_MAX) r_w[i] <= r_w[i] + 1'b1;
                end else begin
                    if (r_w[i] != '0) r_w[i] <= r_w[i] - 1'b1;
                end
            end
        end
    end

    assign w_wt = r_w;
`else
    logic w_unused_learn;
    assign w_unused_learn = i_learn;
    assign w_wt = {N_IN{W_RST}};
`endif
endmodule

// File: rtl/snn_lif_layer.sv
// Layer of N_OUT LIF neurons with windowed integration and winner-take-all learning.
// Define SNN_LEARN_EN to enable the weight update in the LEARN state.
//   state    | meaning
//   IDLE     | in_ready high, waiting for a pattern
//   INTEG    | T_WIN leaky integration cycles, then one terminal cycle
//   LEARN    | done pulse, winner row update (if enabled), back to IDLE
module snn_lif_layer
    import snn_pkg::*;
#(
    parameter int N_IN       = N_IN_DEF,
    parameter int N_OUT      = N_OUT_DEF,
    parameter int W_W        = W_W_DEF,
    parameter int W_INIT     = W_INIT_DEF,
    parameter int V_W        = V_W_DEF,
    parameter int THRESH     = THRESH_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int T_WIN      = T_WIN_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     learn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN-1:0]          pattern,
    input  logic [N_IN-1:0]          rand_bits,
    output logic [N_OUT-1:0]         spike,
    output logic                     done,
    output logic                     win_valid,
    output logic [$clog2(N_OUT)-1:0] win_idx
);
    localparam int IDX_W = $clog2(N_OUT);
    localparam int CNT_W = $clog2(T_WIN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(T_WIN);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N_IN-1:0]  r_pat;
    logic [N_OUT-1:0] r_spike;
    logic             r_done;
    logic             r_win_valid;
    logic [IDX_W-1:0] r_win_idx;
    logic             r_hit;
    logic [IDX_W-1:0] r_hit_idx;
    logic             w_accept;
    logic             w_integ;
    logic             w_win_end;
    logic [N_OUT-1:0] w_fire;
    logic [N_OUT-1:0] w_learn_row;
    logic [IDX_W-1:0] w_first;

    assign in_ready  = (r_state == ST_IDLE);
    assign w_accept  = in_valid && in_ready;
    // Terminal count cycle integrates nothing so no spike can land in LEARN.
    assign w_integ   = (r_state == ST_INTEG) && (r_cnt != '0);
    assign w_win_end = (r_state == ST_INTEG) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pat   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_INTEG;
                        r_cnt   <= CNT_LOAD;
                        r_pat   <= pattern;
                    end
                end
                ST_INTEG: begin
                    if (r_cnt == '0) r_state <= ST_LEARN;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                ST_LEARN: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_first = '0;
        for (int j = N_OUT - 1; j >= 0; j--)
            if (w_fire[j]) w_first = IDX_W'(j);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_spike     <= '0;
            r_done      <= 1'b0;
            r_win_valid <= 1'b0;
            r_win_idx   <= '0;
            r_hit       <= 1'b0;
            r_hit_idx   <= '0;
        end else begin
            r_spike <= w_fire;
            r_done  <= w_win_end;
            if (w_accept) begin
                r_hit       <= 1'b0;
                r_win_valid <= 1'b0;
            end else if (w_integ && !r_hit && (|w_fire)) begin
                r_hit     <= 1'b1;
                r_hit_idx <= w_first;
            end
            if (w_win_end) begin
                r_win_valid <= r_hit;
                if (r_hit) r_win_idx <= r_hit_idx;
            end
        end
    end

`ifdef SNN_LEARN_EN
    always_comb begin
        w_learn_row = '0;
        for (int j = 0; j < N_OUT; j++)
            if ((r_state == ST_LEARN) && learn && r_win_valid && (r_win_idx == IDX_W'(j)))
                w_learn_row[j] = 1'b1;
    end
`else
    logic w_unused_learn;
    assign w_unused_learn = learn;
    assign w_learn_row    = '0;
`endif

    for (genvar g = 0; g < N_OUT; g++) begin : g_neu
        snn_lif_neuron #(
            .N_IN      (N_IN),
            .W_W       (W_W),
            .W_INIT    (W_INIT),
            .V_W       (V_W),
            .THRESH    (THRESH),
            .LEAK_SHIFT(LEAK_SHIFT)
        ) u_neu (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_clr    (w_accept),
            .i_integ  (w_integ),
            .i_learn  (w_learn_row[g]),
            .i_pattern(r_pat),
            .i_rand   (rand_bits),
            .o_fire   (w_fire[g])
        );
    end

    assign spike     = r_spike;
    assign done      = r_done;
    assign win_valid = r_win_valid;
    assign win_idx   = r_win_idx;
endmodule

// File: tb/tb_snn_lif_layer.sv
// Directed self-checking bench for snn_lif_layer; expectations follow SNN_LEARN_EN if defined.
module tb_snn_lif_layer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        learn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] pattern = '0;
    logic [24:0] rand_bits = '1;
    logic [9:0]  spike;
    logic        done;
    logic        win_valid;
    logic [3:0]  win_idx;

    int n_chk = 0;
    int n_err = 0;
    int k = 0;
    int kd;
    logic [9:0] sp_or;

    always #5 clk = ~clk;

    snn_lif_layer dut (
        .clk(clk), .rst_n(rst_n), .learn(learn), .in_valid(in_valid), .in_ready(in_ready),
        .pattern(pattern), .rand_bits(rand_bits), .spike(spike), .done(done),
        .win_valid(win_valid), .win_idx(win_idx)
    );

    logic [99:0] tb_w [10];
    for (genvar g = 0; g < 10; g++) begin : g_tap
        assign tb_w[g] = dut.g_neu[g].u_neu.w_wt;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [99:0] mk_row(input logic [24:0] pat, input logic [3:0] a, input logic [3:0] b);
        logic [99:0] r;
        for (int i = 0; i < 25; i++) r[i*4 +: 4] = pat[i] ? a : b;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic accept(input logic [24:0] pat, input logic lrn);
        pattern  = pat;
        learn    = lrn;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
    endtask

    task automatic wait_done(output int kdone);
        kdone = -1;
        for (int n = 0; n < 400 && kdone < 0; n++) begin
            tick();
            sp_or = sp_or | spike;
            if (done) kdone = k;
        end
    endtask

    localparam logic [24:0] P_ALL = 25'h1FF_FFFF;
    localparam logic [24:0] P_LO  = 25'h000_1FFF;
    localparam logic [24:0] P_HI  = 25'h1FF_E000;
    localparam logic [3:0]  W8    = 4'd8;

    initial begin
        int ndone;
        logic [99:0] all8;
        all8 = mk_row(P_ALL, W8, W8);

        // reset state
        do_reset();
        chk("rst_spike", spike, 10'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_wv", win_valid, 1'b0);
        chk("rst_widx", win_idx, 4'd0);
        chk("rst_w0", tb_w[0], all8);
        chk("rst_w9", tb_w[9], all8);

        // zero pattern: no spikes, done at T_WIN+1, no winner, no learning
        rand_bits = P_ALL;
        accept('0, 1'b1);
        chk("z_ready_busy", in_ready, 1'b0);
        sp_or = '0;
        for (int n = 0; n < 49; n++) tick();
        pattern = P_ALL;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(kd);
        chk("z_done_lat", kd, 337);
        chk("z_no_spike", sp_or, 10'h0);
        chk("z_wv", win_valid, 1'b0);
        tick();
        chk("z_done_pulse", done, 1'b0);
        chk("z_ready_back", in_ready, 1'b1);
        chk("z_w0", tb_w[0], all8);

        // all-ones pattern: 200, 388, 564 -> fire 3 cycles after accept
        accept(P_ALL, 1'b0);
        tick(); chk("a_sp1", spike, 10'h0);
        tick(); chk("a_sp2", spike, 10'h0);
        tick(); chk("a_sp3", spike, 10'h3FF);
        tick(); chk("a_sp4", spike, 10'h0);
        sp_or = '0;
        wait_done(kd);
        chk("a_done_lat", kd, 337);
        chk("a_learn_spk", spike, 10'h0);
        chk("a_wv", win_valid, 1'b1);
        chk("a_widx", win_idx, 4'd0);
        tick();
        chk("a_w0", tb_w[0], all8);

        // stochastic gate: rand_bits restricts input to bits 0..12 -> fire at 5
        rand_bits = P_LO;
        accept(P_ALL, 1'b0);
        for (int n = 0; n < 4; n++) tick();
        chk("g_sp4", spike, 10'h0);
        tick();
        chk("g_sp5", spike, 10'h3FF);
        wait_done(kd);
        tick();
        rand_bits = P_ALL;

        // learn on bits 0..12: 104, 202, 294, 380, 461 -> fire at 5
        accept(P_LO, 1'b1);
        for (int n = 0; n < 4; n++) tick();
        chk("l_sp4", spike, 10'h0);
        tick();
        chk("l_sp5", spike, 10'h3FF);
        wait_done(kd);
        chk("l_done_lat", kd, 337);
        chk("l_wv", win_valid, 1'b1);
        chk("l_widx", win_idx, 4'd0);
        tick();
`ifdef SNN_LEARN_EN
        chk("l_w0", tb_w[0], mk_row(P_LO, 4'd9, 4'd7));
`else
        chk("l_w0", tb_w[0], all8);
`endif
        chk("l_w1", tb_w[1], all8);
        chk("l_w9", tb_w[9], all8);

        // bits 13..24 only: neuron 0 holds 7s there when learning is enabled
        accept(P_HI, 1'b0);
        for (int n = 0; n < 5; n++) tick();
`ifdef SNN_LEARN_EN
        chk("h_sp5", spike, 10'h3FE);
        tick();
        chk("h_sp6", spike, 10'h001);
`else
        chk("h_sp5", spike, 10'h3FF);
        tick();
        chk("h_sp6", spike, 10'h000);
`endif
        wait_done(kd);
`ifdef SNN_LEARN_EN
        chk("h_widx", win_idx, 4'd1);
`else
        chk("h_widx", win_idx, 4'd0);
`endif
        chk("h_wv", win_valid, 1'b1);
        tick();

        // reset at cycle 100 of a learning window
        accept(P_LO, 1'b1);
        for (int n = 0; n < 99; n++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("r_ready", in_ready, 1'b1);
        chk("r_wv", win_valid, 1'b0);
        ndone = 0;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (done) ndone++;
        end
        chk("r_no_done", ndone, 0);
        chk("r_w0", tb_w[0], all8);

        // ten learn windows on bits 0..12: saturate 15 / 0 without wrap
        for (int w = 0; w < 10; w++) begin
            accept(P_LO, 1'b1);
            wait_done(kd);
            tick();
        end
        chk("s_done_lat", kd, 337);
`ifdef SNN_LEARN_EN
        chk("s_w0", tb_w[0], mk_row(P_LO, 4'd15, 4'd0));
`else
        chk("s_w0", tb_w[0], all8);
`endif
        chk("s_w5", tb_w[5], all8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "timeout");
    end
endmodule
